// File: rtl/dice_roller_ndigit.sv
// Dice-roller core. Die-select buttons are synchronised and debounced. Holding a
// button spins a roll counter through the selected die's faces; releasing it
// freezes the value. A sequential double-dabble engine converts the frozen value
// to BCD, and the result is shown on a multiplexed 7-segment display that has
// leading-zero blanking and an inactivity timeout.
module dice_roller_ndigit #(
  parameter int NUM_BTN = 7,
  parameter int VAL_W = 7,
  parameter logic [NUM_BTN*VAL_W-1:0] SIDES = {7'd100, 7'd20, 7'd12, 7'd10, 7'd8, 7'd6, 7'd4},
  parameter int NUM_DIGITS = 3,
  parameter int DEB_TICKS = 2,
  parameter int TIMEOUT_TICKS = 255,
  parameter int SCAN_DIV = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    tick,
  input  logic [NUM_BTN-1:0]      btn,
  input  logic                    seg_pol,
  input  logic                    com_pol,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic [4*NUM_DIGITS-1:0] result,
  output logic                    busy
);

  localparam int DEB_W  = (DEB_TICKS > 1) ? $clog2(DEB_TICKS + 1) : 1;
  localparam int DD_W   = $clog2(VAL_W + 1);
  localparam int TO_W   = $clog2(TIMEOUT_TICKS + 1);
  localparam int SCAN_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int BCD_W  = 4 * NUM_DIGITS;

  typedef enum logic [1:0] {S_IDLE, S_ROLL, S_CONV} state_t;

  // ---------------- input conditioning ----------------
  logic [NUM_BTN-1:0] sync1_reg, sync2_reg;
  logic [NUM_BTN-1:0] deb;
  logic               any;

  // Two-flop synchroniser for the asynchronous button pins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_reg <= '0;
      sync2_reg <= '0;
    end else begin
      sync1_reg <= btn;
      sync2_reg <= sync1_reg;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_BTN; gi++) begin : g_deb
      logic [DEB_W-1:0] cnt_reg;
      logic             state_reg;

      // Flip the debounced level only after DEB_TICKS consecutive differing ticks.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          cnt_reg   <= '0;
          state_reg <= 1'b0;
        end else if (tick) begin
          if (sync2_reg[gi] != state_reg) begin
            if (cnt_reg == DEB_W'(DEB_TICKS - 1)) begin
              state_reg <= sync2_reg[gi];
              cnt_reg   <= '0;
            end else begin
              cnt_reg <= cnt_reg + 1'b1;
            end
          end else begin
            cnt_reg <= '0;
          end
        end
      end

      assign deb[gi] = state_reg;
    end
  endgenerate

  assign any = |deb;

  // ---------------- die selection ----------------
  logic [VAL_W-1:0] sides_sel;

  // Lowest-index pressed button wins; scanning downwards leaves the lowest last.
  always_comb begin
    sides_sel = SIDES[VAL_W-1:0];
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (deb[i]) sides_sel = SIDES[i*VAL_W +: VAL_W];
    end
  end

  // ---------------- roll / conversion FSM ----------------
  state_t           state_reg, state_next;
  logic [VAL_W-1:0] cnt_reg, cnt_next;
  logic [VAL_W-1:0] sides_reg, sides_next;
  logic [DD_W-1:0]  dd_cnt_reg, dd_cnt_next;
  logic [VAL_W-1:0] sh_reg, sh_next;
  logic [BCD_W-1:0] bcd_reg, bcd_next;
  logic [BCD_W-1:0] result_reg, result_next;

  logic [BCD_W-1:0]       bcd_adj;
  logic [BCD_W+VAL_W-1:0] dd_shift;

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_adj
      assign bcd_adj[gi*4 +: 4] = (bcd_reg[gi*4 +: 4] >= 4'd5) ?
                                  bcd_reg[gi*4 +: 4] + 4'd3 : bcd_reg[gi*4 +: 4];
    end
  endgenerate

  // BCD and binary halves shift together so the binary MSB enters the units nibble.
  assign dd_shift = {bcd_adj, sh_reg} << 1;

  // Next-state logic: spin while held, convert after release, publish atomically.
  always_comb begin
    state_next  = state_reg;
    cnt_next    = cnt_reg;
    sides_next  = sides_reg;
    dd_cnt_next = dd_cnt_reg;
    sh_next     = sh_reg;
    bcd_next    = bcd_reg;
    result_next = result_reg;
    case (state_reg)
      S_IDLE: begin
        if (any) begin
          sides_next = sides_sel;
          cnt_next   = sides_sel;
          state_next = S_ROLL;
        end
      end
      S_ROLL: begin
        if (any) begin
          cnt_next = (cnt_reg == VAL_W'(1)) ? sides_reg : cnt_reg - 1'b1;
        end else begin
          dd_cnt_next = DD_W'(VAL_W);
          sh_next     = cnt_reg;
          bcd_next    = '0;
          state_next  = S_CONV;
        end
      end
      S_CONV: begin
        bcd_next    = dd_shift[BCD_W+VAL_W-1:VAL_W];
        sh_next     = dd_shift[VAL_W-1:0];
        dd_cnt_next = dd_cnt_reg - 1'b1;
        if (dd_cnt_reg == DD_W'(1)) begin
          result_next = dd_shift[BCD_W+VAL_W-1:VAL_W];
          state_next  = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= S_IDLE;
      cnt_reg    <= '0;
      sides_reg  <= '0;
      dd_cnt_reg <= '0;
      sh_reg     <= '0;
      bcd_reg    <= '0;
      result_reg <= '0;
    end else begin
      state_reg  <= state_next;
      cnt_reg    <= cnt_next;
      sides_reg  <= sides_next;
      dd_cnt_reg <= dd_cnt_next;
      sh_reg     <= sh_next;
      bcd_reg    <= bcd_next;
      result_reg <= result_next;
    end
  end

  assign busy   = (state_reg != S_IDLE);
  assign result = result_reg;

  // ---------------- inactivity timeout ----------------
  logic [TO_W-1:0] to_reg;
  logic            show;

  // Reload while any button is held; otherwise count ticks down to zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      to_reg <= '0;
    end else if (any) begin
      to_reg <= TO_W'(TIMEOUT_TICKS);
    end else if (tick && (to_reg != '0)) begin
      to_reg <= to_reg - 1'b1;
    end
  end

  assign show = (to_reg != '0) && !busy;

  // ---------------- display multiplexing ----------------
  logic [SCAN_W-1:0]     scan_cnt_reg;
  logic [IDX_W-1:0]      idx_reg;
  logic [NUM_DIGITS-1:0] blank;
  logic [3:0]            cur_digit;
  logic [6:0]            seg_code;
  logic [6:0]            seg_raw_reg;
  logic [NUM_DIGITS-1:0] dig_raw_reg;

  // Free-running slot timer stepping the active digit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scan_cnt_reg <= '0;
      idx_reg      <= '0;
    end else if (scan_cnt_reg == SCAN_W'(SCAN_DIV - 1)) begin
      scan_cnt_reg <= '0;
      idx_reg      <= (idx_reg == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_reg + 1'b1;
    end else begin
      scan_cnt_reg <= scan_cnt_reg + 1'b1;
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_blank
      if (gi == 0) begin : g_units
        assign blank[gi] = 1'b0;
      end else begin : g_upper
        assign blank[gi] = (result_reg[BCD_W-1:4*gi] == '0);
      end
    end
  endgenerate

  assign cur_digit = result_reg[idx_reg*4 +: 4];

  // Active-high 7-segment decode, segment a in bit 0; non-decimal codes stay dark.
  always_comb begin
    seg_code = 7'h00;
    case (cur_digit)
      4'd0: seg_code = 7'h3F;
      4'd1: seg_code = 7'h06;
      4'd2: seg_code = 7'h5B;
      4'd3: seg_code = 7'h4F;
      4'd4: seg_code = 7'h66;
      4'd5: seg_code = 7'h6D;
      4'd6: seg_code = 7'h7D;
      4'd7: seg_code = 7'h07;
      4'd8: seg_code = 7'h7F;
      4'd9: seg_code = 7'h6F;
      default: seg_code = 7'h00;
    endcase
  end

  // Register the active-high display image; polarity is applied after the flops
  // so the reset state is dark for either pin polarity.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg_raw_reg <= '0;
      dig_raw_reg <= '0;
    end else begin
      seg_raw_reg <= seg_code;
      dig_raw_reg <= (show && !blank[idx_reg]) ? (NUM_DIGITS'(1) << idx_reg) : '0;
    end
  end

  assign seg    = seg_pol ? seg_raw_reg : ~seg_raw_reg;
  assign dig_en = com_pol ? dig_raw_reg : ~dig_raw_reg;

endmodule
